imem_port_arbiter: RTL and testbench

- Shares one single-port, byte-wide instruction memory between two requesters:
  - the pipeline fetch stage, which reads 32-bit big-endian instructions;
  - a boot/debug loader, which writes single bytes.
- Sequences each fetch as four byte beats and assembles the instruction word.
- Arbitrates simultaneous requests; sits between the IF stage/loader and the instruction memory array.

---
 rtl/imem_port_arbiter_if.sv | 29 ++
 rtl/imem_port_arbiter.sv | 114 +++++++++++
 tb/tb_imem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Request/response bundle between the IF stage, the boot loader, the
// arbiter and the byte-wide instruction memory.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_inst;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
    output fetch_ack, fetch_inst, ld_ack, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
    input  fetch_ack, fetch_inst, ld_ack, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port byte memory between 4-beat big-endian instruction
// fetches and single-byte loader writes, with round-robin or loader priority.
module imem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter bit RR_EN  = 1'b1
) (
  input logic clk,
  input logic rst,
  imem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, ACK, WR} state_e;

  state_e            state_q;
  logic [1:0]        beat_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              fetch_ack_q;
  logic              ld_ack_q;
  logic [23:0]       asm_q;
  logic [31:0]       inst_q;
  logic              last_fetch_q;

  logic              grant_fetch;
  logic              grant_ld;
  logic [1:0]        beat_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              unused_addr;

  // Tie: round-robin hands the port to whoever did not win last time.
  always_comb begin
    grant_fetch = bus.fetch_req && (!bus.ld_req || (RR_EN && !last_fetch_q));
    grant_ld    = bus.ld_req && !grant_fetch;
    beat_nxt    = beat_q + 2'd1;
    rd_addr_nxt = base_q + ADDR_W'(beat_nxt);
  end

  assign unused_addr = ^bus.fetch_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      fetch_ack_q  <= 1'b0;
      ld_ack_q     <= 1'b0;
      asm_q        <= '0;
      inst_q       <= '0;
      last_fetch_q <= 1'b0;
    end else begin
      fetch_ack_q <= 1'b0;
      ld_ack_q    <= 1'b0;
      we_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_addr_q <= '0;
          wdata_q    <= '0;
          if (grant_fetch) begin
            base_q       <= bus.fetch_addr[ADDR_W-1:0];
            mem_addr_q   <= bus.fetch_addr[ADDR_W-1:0];
            beat_q       <= '0;
            last_fetch_q <= 1'b1;
            state_q      <= RD;
          end else if (grant_ld) begin
            mem_addr_q   <= bus.ld_addr;
            wdata_q      <= bus.ld_data;
            we_q         <= 1'b1;
            ld_ack_q     <= 1'b1;
            last_fetch_q <= 1'b0;
            state_q      <= WR;
          end
        end
        RD: begin
          case (beat_q)
            2'd0: asm_q[23:16] <= bus.mem_rdata;
            2'd1: asm_q[15:8]  <= bus.mem_rdata;
            2'd2: asm_q[7:0]   <= bus.mem_rdata;
            default: ;
          endcase
          if (beat_q == 2'd3) begin
            // Last byte goes straight into the word, no extra cycle.
            inst_q      <= {asm_q, bus.mem_rdata};
            fetch_ack_q <= 1'b1;
            mem_addr_q  <= '0;
            beat_q      <= '0;
            state_q     <= ACK;
          end else begin
            beat_q     <= beat_nxt;
            mem_addr_q <= rd_addr_nxt;
          end
        end
        ACK: state_q <= IDLE;
        WR: begin
          mem_addr_q <= '0;
          wdata_q    <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fetch_ack  = fetch_ack_q;
  assign bus.fetch_inst = inst_q;
  assign bus.ld_ack     = ld_ack_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: transaction-level model with per-cycle compare,
// plus directed fetch/load/tie/reset sequences with literal expectations.
module tb_imem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(16)) bus ();
  imem_port_arbiter_if #(.ADDR_W(16)) bus0 ();

  imem_port_arbiter #(.ADDR_W(16), .RR_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  imem_port_arbiter #(.ADDR_W(16), .RR_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic [7:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus0.mem_rdata = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_tmo(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout waiting for ack (t=%0t)", name, $time);
  endtask

  // Model: position within the current transaction (0 = idle, fetch 1..5, load 1)
  int          m_pos = 0;
  bit          m_fetch, m_last_fetch, m_valid, m_gf;
  logic [15:0] m_base, m_la, m_a;
  logic [7:0]  m_ld;
  logic [31:0] m_inst;

  always @(posedge clk) begin
    if (!rst) begin
      m_pos = 0; m_inst = '0; m_last_fetch = 1'b0; m_valid = 1'b1;
    end else if (m_pos == 0) begin
      m_gf = bus.fetch_req && (!bus.ld_req || !m_last_fetch);
      if (m_gf) begin
        m_fetch = 1'b1; m_pos = 1; m_base = bus.fetch_addr[15:0]; m_last_fetch = 1'b1;
      end else if (bus.ld_req) begin
        m_fetch = 1'b0; m_pos = 1; m_la = bus.ld_addr; m_ld = bus.ld_data; m_last_fetch = 1'b0;
      end
    end else if (m_fetch && m_pos < 5) begin
      m_pos++;
      if (m_pos == 5)
        for (int k = 0; k < 4; k++) begin
          m_a = m_base + 16'(k);
          m_inst = {m_inst[23:0], mem[m_a]};
        end
    end else begin
      m_pos = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(bus.busy), 64'(m_pos != 0));
      chk("fetch_ack", 64'(bus.fetch_ack), 64'(m_fetch && m_pos == 5));
      chk("ld_ack", 64'(bus.ld_ack), 64'(!m_fetch && m_pos == 1));
      chk("mem_we", 64'(bus.mem_we), 64'(!m_fetch && m_pos == 1));
      chk("fetch_inst", 64'(bus.fetch_inst), 64'(m_inst));
      if (m_pos == 0) begin
        chk("idle_addr", 64'(bus.mem_addr), 64'h0);
      end else if (m_fetch && m_pos < 5) begin
        m_a = m_base + 16'(m_pos - 1);
        chk("rd_addr", 64'(bus.mem_addr), 64'(m_a));
      end else if (!m_fetch) begin
        chk("wr_addr", 64'(bus.mem_addr), 64'(m_la));
        chk("wr_data", 64'(bus.mem_wdata), 64'(m_ld));
      end
    end
  end

  task automatic wait_ack(input bit is_fetch, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(is_fetch ? bus.fetch_ack : bus.ld_ack) && n < 100);
    if (n >= 100) fail_tmo(is_fetch ? "fetch" : "load");
  endtask

  task automatic do_load(input logic [15:0] a, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    wait_ack(1'b0, n);
    bus.ld_req = 1'b0;
    chk("load_latency", 64'(n), 64'd2);
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] inst, output logic [63:0] seq);
    int n;
    n = 0; seq = '0;
    @(posedge clk); #1;
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    do begin
      @(negedge clk); n++;
      if (n >= 2 && n <= 5) seq = {seq[47:0], bus.mem_addr};
      if (n == 2) bus.fetch_addr = ~a;
    end while (!bus.fetch_ack && n < 100);
    if (n >= 100) fail_tmo("do_fetch");
    bus.fetch_req = 1'b0;
    inst = bus.fetch_inst;
    chk("fetch_latency", 64'(n), 64'd6);
  endtask

  // Requester loop for the tie tests; gap = extra idle cycles before re-requesting.
  byte ord1[$];
  byte ord0[$];

  initial begin
    logic [31:0] inst;
    logic [63:0] seq;
    logic [31:0] got;
    int n;
    bus.fetch_req = 0; bus.fetch_addr = 0; bus.ld_req = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus0.fetch_req = 0; bus0.fetch_addr = 0; bus0.ld_req = 0; bus0.ld_addr = 0; bus0.ld_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", 64'(bus.fetch_inst), 64'h0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'h0);
    chk("rst_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Basic fetch
    do_load(16'h0010, 8'h20); do_load(16'h0011, 8'h08);
    do_load(16'h0012, 8'h00); do_load(16'h0013, 8'h05);
    do_fetch(32'h0000_0010, inst, seq);
    chk("basic_inst", 64'(inst), 64'h2008_0005);
    chk("basic_seq", seq, 64'h0010_0011_0012_0013);

    // Address wrap, upper fetch_addr bits ignored
    do_load(16'hFFFE, 8'hAA); do_load(16'hFFFF, 8'hBB);
    do_load(16'h0000, 8'hCC); do_load(16'h0001, 8'hDD);
    do_fetch(32'hABCD_FFFE, inst, seq);
    chk("wrap_inst", 64'(inst), 64'hAABB_CCDD);
    chk("wrap_seq", seq, 64'hFFFE_FFFF_0000_0001);

    // Write then read
    do_load(16'h0101, 8'h01); do_load(16'h0102, 8'h02); do_load(16'h0103, 8'h03);
    do_load(16'h0100, 8'hAB);
    do_fetch(32'h0000_0100, inst, seq);
    chk("wtr_byte", 64'(inst[31:24]), 64'hAB);

    // Reset during beat 2
    @(posedge clk); #1;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.mem_addr !== 16'h0012 && n < 50);
    chk("mid_beat2_seen", 64'(n), 64'd4);
    rst = 1'b0; bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(bus.busy), 64'h0);
    chk("mid_inst", 64'(bus.fetch_inst), 64'h0);
    chk("mid_we", 64'(bus.mem_we), 64'h0);
    chk("mid_ack", 64'(bus.fetch_ack), 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    repeat (8) begin @(negedge clk); if (bus.fetch_ack) n++; end
    chk("mid_no_ack", 64'(n), 64'd0);

    // Fetch held through ACK; then loader arrives during ACK
    @(posedge clk); #1;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h10;
    wait_ack(1'b1, n);
    wait_ack(1'b1, n);
    chk("held_refetch", 64'(n), 64'd6);
    chk("held_inst", 64'(bus.fetch_inst), 64'h2008_0005);
    bus.ld_req = 1'b1; bus.ld_addr = 16'h0200; bus.ld_data = 8'h5A;
    wait_ack(1'b0, n);
    chk("ack_ld_first", 64'(n), 64'd2);
    bus.ld_req = 1'b0;
    wait_ack(1'b1, n);
    chk("ack_fetch_after", 64'(n), 64'd6);
    bus.fetch_req = 1'b0;

    // Ties from reset release on both DUTs
    @(negedge clk); rst = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h10;
    bus.ld_req = 1'b1; bus.ld_addr = 16'h0300; bus.ld_data = 8'h77;
    bus0.fetch_req = 1'b1; bus0.fetch_addr = 32'h40;
    bus0.ld_req = 1'b1; bus0.ld_addr = 16'h0400; bus0.ld_data = 8'h11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fork
      for (int i = 0; i < 2; i++) begin
        int t = 0;
        bus.fetch_req = 1'b1;
        do begin @(negedge clk); t++; end while (!bus.fetch_ack && t < 200);
        if (t >= 200) fail_tmo("rr1_fetch");
        ord1.push_back("F"); bus.fetch_req = 1'b0;
        @(posedge clk); #1;
      end
      for (int i = 0; i < 2; i++) begin
        int t = 0;
        bus.ld_req = 1'b1;
        do begin @(negedge clk); t++; end while (!bus.ld_ack && t < 200);
        if (t >= 200) fail_tmo("rr1_load");
        ord1.push_back("L"); bus.ld_req = 1'b0;
        @(posedge clk); #1;
      end
      for (int i = 0; i < 2; i++) begin
        int t = 0;
        bus0.fetch_req = 1'b1;
        do begin @(negedge clk); t++; end while (!bus0.fetch_ack && t < 200);
        if (t >= 200) fail_tmo("rr0_fetch");
        ord0.push_back("F"); bus0.fetch_req = 1'b0;
        repeat (2) @(posedge clk); #1;
      end
      for (int i = 0; i < 2; i++) begin
        int t = 0;
        bus0.ld_req = 1'b1;
        do begin @(negedge clk); t++; end while (!bus0.ld_ack && t < 200);
        if (t >= 200) fail_tmo("rr0_load");
        ord0.push_back("L"); bus0.ld_req = 1'b0;
        repeat (2) @(posedge clk); #1;
      end
    join
    chk("rr1_count", 64'(ord1.size()), 64'd4);
    chk("rr0_count", 64'(ord0.size()), 64'd4);
    got = '0;
    foreach (ord1[i]) got = {got[23:0], ord1[i]};
    chk("rr1_order", 64'(got), 64'("FLFL"));
    got = '0;
    foreach (ord0[i]) got = {got[23:0], ord0[i]};
    chk("rr0_order", 64'(got), 64'("LFLF"));

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
